adpcm_stream_ctrl: RTL and testbench
====================================

Name: adpcm_stream_ctrl

Overview:
- Sequencer in front of the ADPCM decoder (ADPCMD).
- Accepts a byte stream of packed 4-bit ADPCM codes through a valid/ready handshake and unpacks each byte into two nibbles.
- Drives the decoder's sop/eop/coded inputs and a decode enable. Flags sop on the first code of a block and eop on the last.
- Tracks decoder latency and produces a sample-valid strobe aligned with the decoder's `decoded` output.

Parameters:
- DWIDTH, 8, input byte width (fixed: 2 codes per byte).
- LENW, 16, width of the block-length field, in bytes.
- DEC_LAT, 1, decoder latency in cycles, from dec_en to `decoded` valid (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a block. Ignored unless in IDLE.
- blk_len  in  LENW  block length in bytes; sampled on start.
- in_data  in  DWIDTH  packed code byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller accepts in_data this cycle.
- sop  out  1  to decoder: first code of block.
- eop  out  1  to decoder: last code of block.
- coded  out  4  to decoder: current code.
- dec_en  out  1  to decoder: decode `coded` this cycle.
- sample_vld  out  1  decoder output valid (dec_en delayed by DEC_LAT).
- busy  out  1  block in progress, including pipeline drain.
- done  out  1  one-cycle pulse when the last sample_vld of a block is emitted.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; delay line cleared. Reset mid-block abandons the block immediately. No eop or done is produced for it.
- States:
  - IDLE: in_ready=0. On start with blk_len!=0, latch len=blk_len, set first=1, go to FETCH. On start with blk_len==0, pulse done on the next cycle and stay in IDLE. busy is never asserted in this case.
  - FETCH: in_ready=1. On in_valid&in_ready:
    - latch the byte into a holding register;
    - drive coded=byte[3:0] and dec_en=1 in the same cycle (combinational from in_data);
    - sop=first; clear first;
    - go to HI.
    - With in_valid=0: dec_en=0, sop=0, eop=0; coded holds its last value.
  - HI: in_ready=0. Drive coded=held[7:4] and dec_en=1. Decrement the remaining-byte count.
    - If remaining was 1: eop=1, go to DRAIN.
    - Else go to FETCH.
  - DRAIN: in_ready=0. Wait until the delay line is empty, then pulse done and return to IDLE.
- sop and eop are asserted only when dec_en=1.
- A 1-byte block gives sop on the low-nibble cycle and eop on the high-nibble cycle. sop and eop are never both high in the same cycle.
- Throughput: one code per cycle while in_valid stays high, i.e. a byte every 2 cycles.
- sample_vld is dec_en shifted through a DEC_LAT-deep register chain.
- busy=1 from the cycle after an accepted start until the done pulse, inclusive.
- done coincides with the cycle after the final sample_vld.
- blk_len wraps nowhere: the count is unsigned LENW, and the maximum is 2^LENW-1 bytes.
- start during a block (not IDLE) is ignored and has no effect on the count.
- in_valid dropping in the middle of a block simply stalls in FETCH. No timeout.

Optional Feature:
- Macro ADPCM_HIGH_NIBBLE_FIRST_EN.
- Defined: the first code of each byte is byte[7:4] and the second is byte[3:0].
- Undefined (default, WAV IMA order): byte[3:0] first, then byte[7:4].
- sop/eop placement relative to cycles is unchanged.

Decomposition:
- Package adpcm_pkg holds:
  - typedef enum logic [1:0] {IDLE, FETCH, HI, DRAIN} adpcm_ctrl_state_t;
  - localparam CODE_W=4;
  - localparam CODES_PER_BYTE=2.
- Sub-module adpcm_nibble_unpacker holds the byte register and the nibble select, including the macro-dependent ordering.
- The FSM, counters and latency delay line stay in the top level.

Test Plan:
- Reset: nrst low mid-block at byte 2 of 4 -> all outputs 0 immediately. A new start with blk_len=1 then runs normally.
- blk_len=3, bytes 0x21,0x43,0x65 streamed back-to-back:
  - coded = 1,2,3,4,5,6 on 6 consecutive dec_en cycles;
  - sop on code 1, eop on code 6;
  - sample_vld trails by DEC_LAT;
  - one done pulse.
- Same bytes with ADPCM_HIGH_NIBBLE_FIRST_EN -> coded = 2,1,4,3,6,5.
- blk_len=1, byte 0xA5 -> coded 5 (sop) then A (eop), done, busy deasserted.
- Stall: in_valid low for 5 cycles between bytes 1 and 2 of a 2-byte block -> no dec_en during the gap, no extra codes, and sop/eop counted once each.
- start with blk_len=0 -> done pulse next cycle, no dec_en, busy stays 0. A start pulse mid-block is ignored: code count is unchanged.

Source files
------------

// File: rtl/adpcm_stream_ctrl_pkg.sv
// Shared types and constants for the ADPCM stream controller.
package adpcm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HI    = 2'd2,
    DRAIN = 2'd3
  } adpcm_ctrl_state_t;

  localparam int CODE_W         = 4;
  localparam int CODES_PER_BYTE = 2;

endpackage

// File: rtl/adpcm_stream_ctrl_if.sv
// Byte-stream valid/ready interface feeding the ADPCM stream controller.
interface adpcm_stream_ctrl_if #(
  parameter int DWIDTH = 8
);

  logic [DWIDTH-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/adpcm_stream_ctrl_unpacker.sv
// Nibble unpacker: first code comes straight from the incoming byte, second from a held copy.
// Ordering selected by ADPCM_HIGH_NIBBLE_FIRST_EN (default: low nibble first).
module adpcm_nibble_unpacker
  import adpcm_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load,
  input  logic [DWIDTH-1:0] data_in,
  output logic [CODE_W-1:0] first_code,
  output logic [CODE_W-1:0] second_code
);

  logic [CODE_W-1:0] lo_nib_s;
  logic [CODE_W-1:0] hi_nib_s;
  logic [CODE_W-1:0] held_d;
  logic [CODE_W-1:0] held_q;

  assign lo_nib_s = data_in[CODE_W-1:0];
  assign hi_nib_s = data_in[CODES_PER_BYTE*CODE_W-1:CODE_W];

`ifdef ADPCM_HIGH_NIBBLE_FIRST_EN
  assign first_code = hi_nib_s;
  always_comb begin
    if (load) begin
      held_d = lo_nib_s;
    end else begin
      held_d = held_q;
    end
  end
`else
  assign first_code = lo_nib_s;
  always_comb begin
    if (load) begin
      held_d = hi_nib_s;
    end else begin
      held_d = held_q;
    end
  end
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      held_q <= {CODE_W{1'b0}};
    end else begin
      held_q <= held_d;
    end
  end

  assign second_code = held_q;

endmodule

// File: rtl/adpcm_stream_ctrl.sv
// ADPCM decoder sequencer: unpacks bytes into codes, frames sop/eop, tracks decoder latency.
// Nibble order is selected by ADPCM_HIGH_NIBBLE_FIRST_EN (see adpcm_nibble_unpacker).
module adpcm_stream_ctrl
  import adpcm_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int LENW    = 16,
  parameter int DEC_LAT = 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic [LENW-1:0]    blk_len,
  adpcm_stream_ctrl_if.slave s_if,
  output logic               sop,
  output logic               eop,
  output logic [CODE_W-1:0]  coded,
  output logic               dec_en,
  output logic               sample_vld,
  output logic               busy,
  output logic               done
);

  adpcm_ctrl_state_t state_q, state_d;
  logic [LENW-1:0]    rem_q, rem_d;
  logic               first_q, first_d;
  logic [CODE_W-1:0]  coded_q, coded_d;
  logic [DEC_LAT-1:0] dl_q, dl_d, dl_shift_s;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept_s;
  logic               in_ready_s;
  logic               dec_en_s;
  logic               sop_s;
  logic               eop_s;
  logic [CODE_W-1:0]  first_code_s;
  logic [CODE_W-1:0]  second_code_s;

  adpcm_nibble_unpacker #(.DWIDTH(DWIDTH)) u_unpack (
    .clk         (clk),
    .nrst        (nrst),
    .load        (accept_s),
    .data_in     (s_if.in_data),
    .first_code  (first_code_s),
    .second_code (second_code_s)
  );

  assign dl_shift_s = dl_q << 1;

  // Next-state, counters and the combinational decoder drive
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    first_d    = first_q;
    done_d     = 1'b0;
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    dec_en_s   = 1'b0;
    sop_s      = 1'b0;
    eop_s      = 1'b0;
    coded_d    = coded_q;
    case (state_q)
      IDLE: begin
        if (start && (blk_len != {LENW{1'b0}})) begin
          rem_d   = blk_len;
          first_d = 1'b1;
          state_d = FETCH;
        end else if (start) begin
          done_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        in_ready_s = 1'b1;
        if (s_if.in_valid) begin
          accept_s = 1'b1;
          dec_en_s = 1'b1;
          coded_d  = first_code_s;
          sop_s    = first_q;
          first_d  = 1'b0;
          state_d  = HI;
        end else begin
          state_d = FETCH;
        end
      end
      HI: begin
        dec_en_s = 1'b1;
        coded_d  = second_code_s;
        rem_d    = rem_q - LENW'(1);
        if (rem_q == LENW'(1)) begin
          eop_s   = 1'b1;
          state_d = DRAIN;
        end else begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // Delay line empty after this edge means the last sample_vld is out now.
        if (dl_shift_s == {DEC_LAT{1'b0}}) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    dl_d   = dl_shift_s | DEC_LAT'(dec_en_s);
    busy_d = (state_d != IDLE) || (state_q == DRAIN);
  end

  // State, counters, delay line and registered status outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      rem_q   <= {LENW{1'b0}};
      first_q <= 1'b0;
      coded_q <= {CODE_W{1'b0}};
      dl_q    <= {DEC_LAT{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      coded_q <= coded_d;
      dl_q    <= dl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign s_if.in_ready = in_ready_s;
  assign sop           = sop_s;
  assign eop           = eop_s;
  assign coded         = coded_d;
  assign dec_en        = dec_en_s;
  assign sample_vld    = dl_q[DEC_LAT-1];
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_adpcm_stream_ctrl.sv
// Directed self-checking bench for adpcm_stream_ctrl; expectations follow ADPCM_HIGH_NIBBLE_FIRST_EN.
module tb_adpcm_stream_ctrl;

  localparam int LAT = 1;

`ifdef ADPCM_HIGH_NIBBLE_FIRST_EN
  localparam int EXP_B3 [6]    = '{2, 1, 4, 3, 6, 5};
  localparam int EXP_B1 [2]    = '{10, 5};
  localparam int EXP_STALL [4] = '{8, 7, 11, 9};
  localparam int EXP_HOLD      = 7;
  localparam int EXP_MID [4]   = '{1, 0, 3, 2};
  localparam int EXP_RST [2]   = '{3, 12};
`else
  localparam int EXP_B3 [6]    = '{1, 2, 3, 4, 5, 6};
  localparam int EXP_B1 [2]    = '{5, 10};
  localparam int EXP_STALL [4] = '{7, 8, 9, 11};
  localparam int EXP_HOLD      = 8;
  localparam int EXP_MID [4]   = '{0, 1, 2, 3};
  localparam int EXP_RST [2]   = '{12, 3};
`endif

  logic        clk;
  logic        nrst;
  logic        start;
  logic [15:0] blk_len;
  logic        sop, eop, dec_en, sample_vld, busy, done;
  logic [3:0]  coded;

  adpcm_stream_ctrl_if #(.DWIDTH(8)) bus ();

  adpcm_stream_ctrl #(.DWIDTH(8), .LENW(16), .DEC_LAT(LAT)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .blk_len    (blk_len),
    .s_if       (bus.slave),
    .sop        (sop),
    .eop        (eop),
    .coded      (coded),
    .dec_en     (dec_en),
    .sample_vld (sample_vld),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: sole writer of the event log, samples 2 time units after each falling edge.
  int         cyc = 0;
  logic [3:0] code_log [$];
  int         code_cyc [$];
  int         sop_idx [$];
  int         eop_idx [$];
  int         n_svld = 0, n_done = 0, n_busy = 0;
  int         n_align_err = 0, n_both = 0, n_stray = 0;
  int         last_svld_cyc = -1, last_done_cyc = -1, last_start_cyc = -1;
  int         busy_at_done = 0;
  logic [LAT-1:0] hist = '0;

  always begin
    @(negedge clk);
    #2;
    if (!nrst) begin
      hist = '0;
    end else begin
      if (dec_en) begin
        if (sop) sop_idx.push_back(code_log.size());
        if (eop) eop_idx.push_back(code_log.size());
        code_log.push_back(coded);
        code_cyc.push_back(cyc);
      end else if (sop || eop) begin
        n_stray++;
      end
      if (sop && eop) n_both++;
      if (sample_vld !== hist[LAT-1]) n_align_err++;
      hist = (hist << 1) | LAT'(dec_en);
      if (sample_vld) begin n_svld++; last_svld_cyc = cyc; end
      if (done) begin n_done++; last_done_cyc = cyc; busy_at_done = int'(busy); end
      if (busy) n_busy++;
      if (start) last_start_cyc = cyc;
    end
    cyc++;
  end

  function automatic logic [31:0] code_at(input int idx);
    if (idx < code_log.size()) return 32'(code_log[idx]);
    return 32'hDEAD;
  endfunction

  task automatic do_start(input logic [15:0] len);
    start   = 1'b1;
    blk_len = len;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) check_eq("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (n_done == base && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  int b_code, b_done, b_svld, b_sop, b_eop, b_busy, b_dec;

  task automatic snap();
    b_code = code_log.size();
    b_done = n_done;
    b_svld = n_svld;
    b_sop  = sop_idx.size();
    b_eop  = eop_idx.size();
    b_busy = n_busy;
  endtask

  initial begin : global_guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "timeout");
  end

  initial begin
    nrst         = 1'b0;
    start        = 1'b0;
    blk_len      = 16'd0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_outputs", {25'd0, bus.in_ready, sop, eop, dec_en, sample_vld, busy, done}, 32'd0);
    check_eq("rst_coded", 32'(coded), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // 3-byte block streamed back-to-back
    snap();
    do_start(16'd3);
    send_byte(8'h21);
    send_byte(8'h43);
    send_byte(8'h65);
    bus.in_valid = 1'b0;
    wait_done(b_done);
    check_eq("b3_count", 32'(code_log.size() - b_code), 32'd6);
    for (int i = 0; i < 6; i++) check_eq($sformatf("b3_code%0d", i), code_at(b_code + i), 32'(EXP_B3[i]));
    check_eq("b3_sop_cnt", 32'(sop_idx.size() - b_sop), 32'd1);
    check_eq("b3_sop_pos", 32'(sop_idx[b_sop] - b_code), 32'd0);
    check_eq("b3_eop_cnt", 32'(eop_idx.size() - b_eop), 32'd1);
    check_eq("b3_eop_pos", 32'(eop_idx[b_eop] - b_code), 32'd5);
    check_eq("b3_throughput", 32'(code_cyc[b_code + 5] - code_cyc[b_code]), 32'd5);
    check_eq("b3_svld_cnt", 32'(n_svld - b_svld), 32'd6);
    check_eq("b3_done_cnt", 32'(n_done - b_done), 32'd1);
    check_eq("b3_done_timing", 32'(last_done_cyc - last_svld_cyc), 32'd1);
    check_eq("b3_busy_at_done", 32'(busy_at_done), 32'd1);
    check_eq("b3_busy_after", 32'(busy), 32'd0);

    // 1-byte block
    snap();
    do_start(16'd1);
    send_byte(8'hA5);
    bus.in_valid = 1'b0;
    wait_done(b_done);
    check_eq("b1_count", 32'(code_log.size() - b_code), 32'd2);
    check_eq("b1_code0", code_at(b_code), 32'(EXP_B1[0]));
    check_eq("b1_code1", code_at(b_code + 1), 32'(EXP_B1[1]));
    check_eq("b1_sop_pos", 32'(sop_idx[b_sop] - b_code), 32'd0);
    check_eq("b1_eop_pos", 32'(eop_idx[b_eop] - b_code), 32'd1);
    check_eq("b1_done_cnt", 32'(n_done - b_done), 32'd1);
    check_eq("b1_busy_after", 32'(busy), 32'd0);

    // 2-byte block with in_valid low between the bytes
    snap();
    do_start(16'd2);
    send_byte(8'h87);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_eq("stall_dec_en", 32'(dec_en), 32'd0);
    check_eq("stall_coded_hold", 32'(coded), 32'(EXP_HOLD));
    repeat (3) @(negedge clk);
    send_byte(8'hB9);
    bus.in_valid = 1'b0;
    wait_done(b_done);
    check_eq("stall_count", 32'(code_log.size() - b_code), 32'd4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("stall_code%0d", i), code_at(b_code + i), 32'(EXP_STALL[i]));
    check_eq("stall_gap", 32'(code_cyc[b_code + 2] - code_cyc[b_code + 1]), 32'd6);
    check_eq("stall_sop_cnt", 32'(sop_idx.size() - b_sop), 32'd1);
    check_eq("stall_eop_cnt", 32'(eop_idx.size() - b_eop), 32'd1);
    check_eq("stall_done_cnt", 32'(n_done - b_done), 32'd1);

    // Zero-length start
    snap();
    do_start(16'd0);
    repeat (3) @(negedge clk);
    check_eq("zero_done_cnt", 32'(n_done - b_done), 32'd1);
    check_eq("zero_done_timing", 32'(last_done_cyc - last_start_cyc), 32'd1);
    check_eq("zero_no_dec", 32'(code_log.size() - b_code), 32'd0);
    check_eq("zero_no_busy", 32'(n_busy - b_busy), 32'd0);

    // Start pulse mid-block is ignored
    snap();
    do_start(16'd2);
    send_byte(8'h10);
    do_start(16'd5);
    send_byte(8'h32);
    bus.in_valid = 1'b0;
    wait_done(b_done);
    repeat (4) @(negedge clk);
    check_eq("mid_count", 32'(code_log.size() - b_code), 32'd4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("mid_code%0d", i), code_at(b_code + i), 32'(EXP_MID[i]));
    check_eq("mid_done_cnt", 32'(n_done - b_done), 32'd1);

    // Reset mid-block at byte 2 of 4, then a clean 1-byte block
    snap();
    do_start(16'd4);
    send_byte(8'h11);
    bus.in_data = 8'h22;
    @(negedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check_eq("midrst_outputs", {25'd0, bus.in_ready, sop, eop, dec_en, sample_vld, busy, done}, 32'd0);
    check_eq("midrst_coded", 32'(coded), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("midrst_no_done", 32'(n_done - b_done), 32'd0);
    b_dec = code_log.size();
    do_start(16'd1);
    send_byte(8'h3C);
    bus.in_valid = 1'b0;
    wait_done(b_done);
    check_eq("rerun_count", 32'(code_log.size() - b_dec), 32'd2);
    check_eq("rerun_code0", code_at(b_dec), 32'(EXP_RST[0]));
    check_eq("rerun_code1", code_at(b_dec + 1), 32'(EXP_RST[1]));
    check_eq("rerun_done_cnt", 32'(n_done - b_done), 32'd1);
    check_eq("rerun_busy_after", 32'(busy), 32'd0);

    // Whole-run framing invariants
    check_eq("sop_eop_together", 32'(n_both), 32'd0);
    check_eq("sop_eop_without_dec_en", 32'(n_stray), 32'd0);
    check_eq("svld_alignment", 32'(n_align_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
